// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types: RAM status, word, FSM state and grant class.
// Imported by the interface, the picker and the arbiter top.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_class_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side bundle of the memory arbiter.
// slave is the arbiter view, master is the caches-plus-RAM view.
interface mem_arbiter_if #(
  parameter int NCORES = 2
);
  import mem_arbiter_pkg::*;

  logic [NCORES-1:0] iREN;
  word_t [NCORES-1:0] iaddr;
  logic [NCORES-1:0] iwait;
  word_t [NCORES-1:0] iload;
  logic [NCORES-1:0] dREN;
  logic [NCORES-1:0] dWEN;
  word_t [NCORES-1:0] daddr;
  word_t [NCORES-1:0] dstore;
  logic [NCORES-1:0] dwait;
  word_t [NCORES-1:0] dload;
  logic ramREN;
  logic ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN,
    input  daddr, dstore,
    input  ramload, ramstate,
    output iwait, iload, dwait, dload,
    output ramREN, ramWEN,
    output ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN,
    output daddr, dstore,
    output ramload, ramstate,
    input  iwait, iload, dwait, dload,
    input  ramREN, ramWEN,
    input  ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: first active request at or after ptr,
// ascending with wrap.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic [IW-1:0] k;
    any = 1'b0;
    idx = ptr;
    k   = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (!any && req[k]) begin
        any = 1'b1;
        idx = k;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between per-core icaches and dcaches.
// dcache beats icache; round-robin across cores within a class.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCORES    = 2,
  parameter int BURST_MAX = 4
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int CW = $clog2(BURST_MAX) + 1;

  arb_state_t    state, nstate;
  gnt_class_t    gcls, ngcls;
  logic [IW-1:0] gcore, ngcore;
  logic [IW-1:0] rr, nrr, rr_adv;
  logic [CW-1:0] cnt, ncnt, cnt_acc;

  logic          iany, dany;
  logic [IW-1:0] iidx, didx;
  logic [NCORES-1:0] dreq;
  logic          access, dact, rel;

  assign dreq    = bus.dREN | bus.dWEN;
  assign access  = (bus.ramstate == ACCESS);
  assign dact    = dreq[gcore];
  assign cnt_acc = cnt + CW'(access);
  assign rr_adv  = (gcore == IW'(NCORES - 1))
                 ? '0 : gcore + 1'b1;

  rr_picker #(.N(NCORES), .IW(IW)) u_ipick (
    .req (bus.iREN),
    .ptr (rr),
    .any (iany),
    .idx (iidx)
  );

  rr_picker #(.N(NCORES), .IW(IW)) u_dpick (
    .req (dreq),
    .ptr (rr),
    .any (dany),
    .idx (didx)
  );

  // ERROR is a stall: it neither counts nor releases
  always_comb begin
    rel = 1'b0;
    if (state == XFER) begin
      unique case (gcls)
        GNT_I: rel = access | ~bus.iREN[gcore];
        GNT_D: rel = ~dact
                   | (cnt_acc == CW'(BURST_MAX));
        default: rel = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ARB;
      gcls  <= GNT_I;
      gcore <= '0;
      rr    <= '0;
      cnt   <= '0;
    end else begin
      state <= nstate;
      gcls  <= ngcls;
      gcore <= ngcore;
      rr    <= nrr;
      cnt   <= ncnt;
    end
  end

  always_comb begin
    nstate = state;
    ngcls  = gcls;
    ngcore = gcore;
    nrr    = rr;
    ncnt   = cnt;
    unique case (state)
      ARB: begin
        if (dany) begin
          nstate = XFER;
          ngcls  = GNT_D;
          ngcore = didx;
        end else if (iany) begin
          nstate = XFER;
          ngcls  = GNT_I;
          ngcore = iidx;
        end
      end
      XFER: begin
        if (rel) begin
          nstate = ARB;
          nrr    = rr_adv;
          ncnt   = '0;
        end else if (gcls == GNT_D) begin
          ncnt = cnt_acc;
        end
      end
      default: nstate = ARB;
    endcase
  end

  always_comb begin
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (state == XFER) begin
      unique case (gcls)
        GNT_D: begin
          bus.ramWEN   = bus.dWEN[gcore];
          bus.ramREN   = bus.dREN[gcore]
                       & ~bus.dWEN[gcore];
          bus.ramaddr  = bus.daddr[gcore];
          bus.ramstore = bus.dstore[gcore];
          bus.dwait[gcore] = ~access;
          bus.dload[gcore] = bus.ramload;
        end
        GNT_I: begin
          bus.ramREN  = bus.iREN[gcore];
          bus.ramaddr = bus.iaddr[gcore];
          bus.iwait[gcore] = ~access;
          bus.iload[gcore] = bus.ramload;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with 2 cores.
// Each vector drives one cycle and checks outputs mid-cycle.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    logic [1:0] iren;
    logic [1:0] dren;
    logic [1:0] dwen;
    logic [1:0] rs;
    word_t      ld;
    logic [1:0] gi;
    logic [1:0] gd;
    logic [1:0] iw;
    logic [1:0] dw;
    logic       ren;
    logic       wen;
    word_t      addr;
    word_t      store;
  } vec_t;

  logic CLK;
  logic nRST;
  int   ntests;
  int   nfail;

  mem_arbiter_if #(.NCORES(2)) bus ();

  mem_arbiter #(.NCORES(2), .BURST_MAX(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(
    logic [1:0] iren, logic [1:0] dren,
    logic [1:0] dwen, logic [1:0] rs,
    word_t ld, logic [1:0] gi, logic [1:0] gd,
    logic [1:0] iw, logic [1:0] dw,
    logic ren, logic wen,
    word_t addr, word_t store);
    vec_t v;
    v.iren = iren; v.dren = dren; v.dwen = dwen;
    v.rs = rs; v.ld = ld; v.gi = gi; v.gd = gd;
    v.iw = iw; v.dw = dw; v.ren = ren; v.wen = wen;
    v.addr = addr; v.store = store;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.iREN     = v.iren;
    bus.dREN     = v.dren;
    bus.dWEN     = v.dwen;
    bus.ramstate = ramstate_t'(v.rs);
    bus.ramload  = v.ld;
  endtask

  task automatic chk_now(input vec_t v, input string nm);
    logic [69:0]  ao, eo;
    logic [127:0] al, el;
    eo = {v.iw, v.dw, v.ren, v.wen, v.addr, v.store};
    ao = {bus.iwait, bus.dwait, bus.ramREN,
          bus.ramWEN, bus.ramaddr, bus.ramstore};
    ntests++;
    if (ao !== eo) begin
      nfail++;
      $display("FAIL %s outputs: got %h expected %h",
               nm, ao, eo);
    end
    el = {v.gi[1] ? v.ld : 32'h0, v.gi[0] ? v.ld : 32'h0,
          v.gd[1] ? v.ld : 32'h0, v.gd[0] ? v.ld : 32'h0};
    al = {bus.iload, bus.dload};
    ntests++;
    if (al !== el) begin
      nfail++;
      $display("FAIL %s loads: got %h expected %h",
               nm, al, el);
    end
  endtask

  task automatic run(input vec_t v, input string nm);
    @(negedge CLK);
    drive(v);
    #1;
    chk_now(v, nm);
  endtask

  vec_t tv[20];
  vec_t hv[10];
  vec_t idle;

  initial begin
    ntests = 0;
    nfail  = 0;
    bus.iaddr[0]  = 32'h40;
    bus.iaddr[1]  = 32'h80;
    bus.daddr[0]  = 32'h100;
    bus.daddr[1]  = 32'h200;
    bus.dstore[0] = 32'hA0;
    bus.dstore[1] = 32'hB1;
    idle = mk(0, 0, 0, FREE, 0, 0, 0, 3, 3, 0, 0, 0, 0);

    // icache core0, then both dcaches, then icache core1,
    // then write-to-read dcache burst, then icache again
    tv[0]  = mk(1, 0, 0, FREE, 0, 0, 0, 3, 3, 0, 0, 0, 0);
    tv[1]  = mk(1, 0, 0, BUSY, 0, 1, 0, 3, 3, 1, 0,
                32'h40, 0);
    tv[2]  = mk(1, 0, 0, ACCESS, 32'hDEADBEEF, 1, 0,
                2, 3, 1, 0, 32'h40, 0);
    tv[3]  = mk(0, 0, 0, FREE, 0, 0, 0, 3, 3, 0, 0, 0, 0);
    tv[4]  = mk(3, 3, 0, FREE, 0, 0, 0, 3, 3, 0, 0, 0, 0);
    tv[5]  = mk(3, 3, 0, ACCESS, 32'h1111, 0, 2,
                3, 1, 1, 0, 32'h200, 32'hB1);
    tv[6]  = mk(3, 1, 0, FREE, 32'h1112, 0, 2,
                3, 3, 0, 0, 32'h200, 32'hB1);
    tv[7]  = mk(3, 1, 0, FREE, 0, 0, 0, 3, 3, 0, 0, 0, 0);
    tv[8]  = mk(3, 1, 0, ACCESS, 32'h2222, 0, 1,
                3, 2, 1, 0, 32'h100, 32'hA0);
    tv[9]  = mk(3, 0, 0, FREE, 32'h2223, 0, 1,
                3, 3, 0, 0, 32'h100, 32'hA0);
    tv[10] = mk(3, 0, 0, FREE, 0, 0, 0, 3, 3, 0, 0, 0, 0);
    tv[11] = mk(3, 0, 0, ACCESS, 32'h3333, 2, 0,
                1, 3, 1, 0, 32'h80, 0);
    tv[12] = mk(1, 0, 1, FREE, 0, 0, 0, 3, 3, 0, 0, 0, 0);
    tv[13] = mk(1, 0, 1, ACCESS, 32'h4444, 0, 1,
                3, 2, 0, 1, 32'h100, 32'hA0);
    tv[14] = mk(1, 1, 1, BUSY, 32'h4445, 0, 1,
                3, 3, 0, 1, 32'h100, 32'hA0);
    tv[15] = mk(1, 1, 0, ACCESS, 32'h5555, 0, 1,
                3, 2, 1, 0, 32'h100, 32'hA0);
    tv[16] = mk(1, 0, 0, FREE, 32'h5556, 0, 1,
                3, 3, 0, 0, 32'h100, 32'hA0);
    tv[17] = mk(1, 0, 0, FREE, 0, 0, 0, 3, 3, 0, 0, 0, 0);
    tv[18] = mk(1, 0, 0, ACCESS, 32'h6666, 1, 0,
                2, 3, 1, 0, 32'h40, 0);
    tv[19] = mk(0, 0, 0, FREE, 0, 0, 0, 3, 3, 0, 0, 0, 0);

    // after reset: both dcaches, core0 capped at 4 words
    // with an ERROR stall, then core1 ahead of icaches
    hv[0] = mk(3, 3, 0, FREE, 0, 0, 0, 3, 3, 0, 0, 0, 0);
    hv[1] = mk(3, 3, 0, ACCESS, 32'hA1, 0, 1,
               3, 2, 1, 0, 32'h100, 32'hA0);
    hv[2] = mk(3, 3, 0, ERROR, 32'hE0, 0, 1,
               3, 3, 1, 0, 32'h100, 32'hA0);
    hv[3] = hv[2];
    hv[4] = hv[2];
    hv[5] = mk(3, 3, 0, ACCESS, 32'hA2, 0, 1,
               3, 2, 1, 0, 32'h100, 32'hA0);
    hv[6] = mk(3, 3, 0, ACCESS, 32'hA3, 0, 1,
               3, 2, 1, 0, 32'h100, 32'hA0);
    hv[7] = mk(3, 3, 0, ACCESS, 32'hA4, 0, 1,
               3, 2, 1, 0, 32'h100, 32'hA0);
    hv[8] = mk(3, 3, 0, FREE, 0, 0, 0, 3, 3, 0, 0, 0, 0);
    hv[9] = mk(3, 3, 0, BUSY, 0, 0, 2,
               3, 3, 1, 0, 32'h200, 32'hB1);

    nRST = 1'b0;
    drive(idle);
    #1;
    chk_now(idle, "reset");
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 20; i++)
      run(tv[i], $sformatf("vec%0d", i));

    run(mk(0, 2, 0, FREE, 0, 0, 0, 3, 3, 0, 0, 0, 0),
        "pre_rst_arb");
    run(mk(0, 2, 0, BUSY, 0, 0, 2, 3, 3, 1, 0,
           32'h200, 32'hB1), "pre_rst_xfer");
    #1;
    nRST = 1'b0;
    #1;
    chk_now(mk(0, 2, 0, BUSY, 0, 0, 0, 3, 3, 0, 0, 0, 0),
            "rst_mid_xfer");
    drive(idle);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 10; i++)
      run(hv[i], $sformatf("burst%0d", i));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
